tacho_meas: RTL and testbench
=============================

# tacho_meas

Two-channel tachometer measurement block that consumes the O_spd1/O_spd2 pulse pair produced by the frequency generator, or the equivalent external speed-sensor inputs. It synchronises and glitch-filters both channels, then measures the channel-1 period and the channel-1→channel-2 phase delay in I_clk cycles. It also derives rotation direction and keeps a signed up/down pulse count. It sits between the pulse pins and the register bank, and provides loop-back self-check of the generator.

## Interface
- FILT_LEN, 4: consecutive stable cycles required before a filtered channel changes (≥1)
- TIMEOUT, 25_000_000: cycles without a channel-1 rising edge before stop is declared (1 s at 25 MHz)
- I_clk  in  1  system clock, 25 MHz
- I_reset_n  in  1  reset, asynchronous, active-low
- I_spd1  in  1  channel 1 speed input, asynchronous to I_clk
- I_spd2  in  1  channel 2 speed input, asynchronous to I_clk
- I_enable  in  1  measurement enable, active high
- I_clear  in  1  single-cycle synchronous pulse, clears O_pulse_cnt
- O_period  out  32  cycles between the last two channel-1 rising edges
- O_phase  out  32  cycles from channel-1 rising edge to next channel-2 rising edge
- O_dir  out  1  0: channel 1 leads; 1: channel 2 leads
- O_pulse_cnt  out  32  up/down pulse count, modulo 2^32
- O_valid  out  1  one-cycle strobe when O_period is updated
- O_stopped  out  1  1 while no valid period measurement exists

## Operation
- Each channel passes through a 2-FF synchroniser, then the filter.
- Filter: a counter runs while the synchronised level ≠ the filtered level. The filtered level flips when the counter reaches FILT_LEN−1 while the mismatch persists. Any match clears the counter.
- r1/r2: rising-edge detects on filtered ch1/ch2 (filtered level vs 1-cycle delayed copy).
- per_cnt (32 b, saturates at 0xFFFFFFFF):
  - loads 0 on r1
  - otherwise increments
- ph_cnt (32 b, saturating):
  - loads 0 on r1
  - otherwise increments
- Phase arm flag:
  - set on r1
  - cleared on r2
- States:
  - IDLE: I_enable=0. per_cnt, ph_cnt and arm are cleared. O_stopped=1. O_period, O_phase, O_dir and O_pulse_cnt hold. I_enable=1 → WAIT_FIRST.
  - WAIT_FIRST: r1 → RUN. No period capture and no O_valid.
  - RUN, on r1: O_period←per_cnt+1, O_valid=1, O_stopped←0.
  - RUN, timeout: when per_cnt = TIMEOUT−1 with no r1 that cycle, O_stopped←1, O_period←0, → WAIT_FIRST.
  - I_enable=0 from any state → IDLE.
- Direction: on every r1 outside IDLE, O_dir←filtered ch2 level at that cycle.
- Pulse count: on every r1 outside IDLE, O_pulse_cnt ±1 using the newly sampled direction (ch2 low → +1, high → −1). It wraps 0xFFFFFFFF↔0.
- I_clear has priority over r1 in the same cycle (result 0). It is honoured in IDLE.
- Phase: on r2 with arm set (not in IDLE), O_phase←ph_cnt+1.
- r1 and r2 in the same cycle: O_phase←0, arm stays set (new r1).
- r2 with arm clear is ignored.

## Timing
- Reset values:
  - O_period=0, O_phase=0, O_dir=0, O_pulse_cnt=0, O_valid=0, O_stopped=1
  - internal counters and filters 0, state IDLE
- Input edge sampled at clock edge t, stable thereafter: the filtered level flips at t+1+FILT_LEN, and the outputs update at edge t+FILT_LEN+2.
- O_valid is high for exactly one cycle, coincident with the O_period update.
- Rising edges spaced k cycles apart give O_period=k. Filter delay is identical on both channels, so O_phase equals the true input delay.
- An asynchronous reset mid-measurement returns to reset values immediately. The first r1 after re-enable only arms the period measurement.

## Test plan
Bench parameters: FILT_LEN=4, TIMEOUT=1000.

1. Enable; ch1 square wave period 100, ch2 lagging 25 cycles → after the 2nd ch1 rise: O_period=100, O_phase=25, O_dir=0, O_valid one cycle per period, O_pulse_cnt +1 per ch1 rise, O_stopped=0.
2. Ch2 leading by 25, O_pulse_cnt starting at 2 → O_dir=1, count 1, 0, 0xFFFFFFFF, 0xFFFFFFFE.
3. 3-cycle high glitch on ch1 → no count change, no O_valid. 4-cycle pulse → counted.
4. Stop ch1 after steady running → O_stopped=1 and O_period=0 exactly 1000 cycles after the last r1. Restart: first rise gives no O_valid, second rise gives a valid O_period.
5. I_clear in the same cycle as r1 → O_pulse_cnt=0. Next rise → 1.
6. Reset asserted mid-RUN, and separately I_enable dropped → all outputs at reset values (reset case). IDLE holds O_period and O_pulse_cnt with O_stopped=1 (disable case).

Source files
------------

// File: rtl/tacho_meas.sv
// tacho_meas: two-channel tachometer measurement.
//   Both speed inputs are synchronised (2 FF) and glitch-filtered. The block
//   measures the channel-1 period and the channel-1 -> channel-2 phase delay
//   in I_clk cycles. It derives the rotation direction and keeps a signed
//   up/down pulse count.
// Parameters:
//   FILT_LEN  consecutive disagreeing samples needed before a filtered level flips (>=1)
//   TIMEOUT   cycles without a channel-1 rise before the period is declared stopped
// Ports:
//   I_clk, I_reset_n     clock, asynchronous active-low reset
//   I_spd1, I_spd2       raw speed inputs (asynchronous)
//   I_enable             measurement enable
//   I_clear              single-cycle pulse, clears O_pulse_cnt (wins over a count step)
//   O_period, O_phase    last channel-1 period / last ch1->ch2 delay, in cycles
//   O_dir                0: channel 1 leads, 1: channel 2 leads
//   O_pulse_cnt          up/down count of channel-1 rises, wraps modulo 2^32
//   O_valid              one-cycle strobe when O_period is updated
//   O_stopped            1 while no valid period measurement exists
module tacho_meas #(
  parameter int unsigned FILT_LEN = 4,
  parameter int unsigned TIMEOUT  = 25_000_000
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_spd1,
  input  logic        I_spd2,
  input  logic        I_enable,
  input  logic        I_clear,
  output logic [31:0] O_period,
  output logic [31:0] O_phase,
  output logic        O_dir,
  output logic [31:0] O_pulse_cnt,
  output logic        O_valid,
  output logic        O_stopped
);

  localparam int unsigned   FW           = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FILT_LAST    = FW'(FILT_LEN - 1);
  localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [1:0] spd_in;
  logic [1:0] rise;

  assign spd_in = {I_spd2, I_spd1};

  // Per channel: synchroniser, mismatch-run-length filter, rising-edge detect.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic          sync1_reg;
      logic          sync2_reg;
      logic          filt_reg;
      logic          filt_d_reg;
      logic [FW-1:0] cnt_reg;

      always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
          sync1_reg  <= 1'b0;
          sync2_reg  <= 1'b0;
          filt_reg   <= 1'b0;
          filt_d_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          sync1_reg  <= spd_in[gi];
          sync2_reg  <= sync1_reg;
          filt_d_reg <= filt_reg;
          // cnt_reg counts disagreeing samples already seen; the FILT_LEN-th
          // consecutive one flips the filtered level.
          if (sync2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == FILT_LAST) begin
            filt_reg <= sync2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign rise[gi] = filt_reg & ~filt_d_reg;
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT_FIRST, RUN} state_t;

  state_t      state_reg;
  logic [31:0] per_cnt_reg;
  logic [31:0] ph_cnt_reg;
  logic [31:0] period_reg;
  logic [31:0] phase_reg;
  logic [31:0] pulse_cnt_reg;
  logic        arm_reg;
  logic        dir_reg;
  logic        valid_reg;
  logic        stopped_reg;

  logic        r1;
  logic        r2;
  logic        ch2_level;
  logic        active;
  logic [31:0] per_inc;
  logic [31:0] ph_inc;
  logic [31:0] cnt_step;

  assign r1        = rise[0];
  assign r2        = rise[1];
  assign ch2_level = g_chan[1].filt_reg;
  assign active    = I_enable && (state_reg != IDLE);
  // Saturating +1: a stuck counter must not wrap into a short, bogus value.
  assign per_inc   = (&per_cnt_reg) ? per_cnt_reg : per_cnt_reg + 32'd1;
  assign ph_inc    = (&ph_cnt_reg)  ? ph_cnt_reg  : ph_cnt_reg  + 32'd1;
  // Channel 2 already high at a channel-1 rise means channel 2 leads: count down.
  assign cnt_step  = ch2_level ? 32'hFFFF_FFFF : 32'd1;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_reg     <= IDLE;
      per_cnt_reg   <= '0;
      ph_cnt_reg    <= '0;
      period_reg    <= '0;
      phase_reg     <= '0;
      pulse_cnt_reg <= '0;
      arm_reg       <= 1'b0;
      dir_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      stopped_reg   <= 1'b1;
    end else begin
      valid_reg <= 1'b0;

      if (I_clear) begin
        pulse_cnt_reg <= '0;
      end else if (active && r1) begin
        pulse_cnt_reg <= pulse_cnt_reg + cnt_step;
      end

      if (!active) begin
        // IDLE (or leaving it): measurements restart from scratch, results hold.
        per_cnt_reg <= '0;
        ph_cnt_reg  <= '0;
        arm_reg     <= 1'b0;
        stopped_reg <= 1'b1;
        state_reg   <= I_enable ? WAIT_FIRST : IDLE;
      end else begin
        per_cnt_reg <= r1 ? 32'd0 : per_inc;
        ph_cnt_reg  <= r1 ? 32'd0 : ph_inc;

        // A coincident ch1/ch2 rise is a zero delay and re-arms for the new ch1 rise.
        if (r2 && r1) begin
          phase_reg <= '0;
        end else if (r2 && arm_reg) begin
          phase_reg <= ph_inc;
        end

        if (r1) begin
          dir_reg <= ch2_level;
          arm_reg <= 1'b1;
        end else if (r2) begin
          arm_reg <= 1'b0;
        end

        case (state_reg)
          WAIT_FIRST: begin
            if (r1) begin
              state_reg <= RUN;
            end
          end
          RUN: begin
            if (r1) begin
              period_reg  <= per_inc;
              valid_reg   <= 1'b1;
              stopped_reg <= 1'b0;
            end else if (per_cnt_reg == TIMEOUT_LAST) begin
              period_reg  <= '0;
              stopped_reg <= 1'b1;
              state_reg   <= WAIT_FIRST;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign O_period    = period_reg;
  assign O_phase     = phase_reg;
  assign O_dir       = dir_reg;
  assign O_pulse_cnt = pulse_cnt_reg;
  assign O_valid     = valid_reg;
  assign O_stopped   = stopped_reg;

endmodule

// File: tb/tb_tacho_meas.sv
// Testbench for tacho_meas: directed scenarios with literal expectations plus
// randomized waveforms, all checked every cycle against a timestamp-based
// behavioural model of the measurement rules.
module tb_tacho_meas;

  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 1000;

  logic        I_clk = 1'b0;
  logic        I_reset_n = 1'b0;
  logic        I_spd1 = 1'b0;
  logic        I_spd2 = 1'b0;
  logic        I_enable = 1'b0;
  logic        I_clear = 1'b0;
  logic [31:0] O_period;
  logic [31:0] O_phase;
  logic        O_dir;
  logic [31:0] O_pulse_cnt;
  logic        O_valid;
  logic        O_stopped;

  tacho_meas #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .I_clk       (I_clk),
    .I_reset_n   (I_reset_n),
    .I_spd1      (I_spd1),
    .I_spd2      (I_spd2),
    .I_enable    (I_enable),
    .I_clear     (I_clear),
    .O_period    (O_period),
    .O_phase     (O_phase),
    .O_dir       (O_dir),
    .O_pulse_cnt (O_pulse_cnt),
    .O_valid     (O_valid),
    .O_stopped   (O_stopped)
  );

  always #20 I_clk = ~I_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_seen = 0;
  int last_valid_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw input history per channel: bit k = value sampled k edges ago.
  logic [15:0]     hist1 = '0, hist2 = '0;
  bit              mf1 = 0, mf2 = 0;        // filtered levels
  bit              pend1 = 0, pend2 = 0;    // rise seen, acts at the next edge
  longint unsigned edge_n = 0;
  longint unsigned t_r1 = 0;                // edge of the most recent ch1 rise
  int              mstate = 0;              // 0 idle, 1 waiting first rise, 2 running
  bit              m_arm = 0;
  logic [31:0]     m_period = '0, m_phase = '0, m_cnt = '0;
  bit              m_dir = 0, m_valid = 0, m_stopped = 1;

  // A filtered level changes once the synchronised input (two edges old) has
  // disagreed with it for FILT_LEN consecutive samples.
  function automatic bit must_flip(input logic [15:0] h, input bit lvl);
    for (int k = 2; k <= FILT_LEN + 1; k++) begin
      if (h[k] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    bit r1, r2, active, f1, f2;
    if (!I_reset_n) begin
      hist1 = '0; hist2 = '0; mf1 = 0; mf2 = 0; pend1 = 0; pend2 = 0;
      mstate = 0; m_arm = 0; m_period = '0; m_phase = '0; m_cnt = '0;
      m_dir = 0; m_valid = 0; m_stopped = 1;
      return;
    end
    edge_n++;
    r1 = pend1;
    r2 = pend2;
    m_valid = 0;
    active = I_enable && (mstate != 0);
    if (I_clear) m_cnt = '0;
    else if (active && r1) m_cnt = mf2 ? m_cnt - 32'd1 : m_cnt + 32'd1;
    if (!active) begin
      m_arm = 0;
      m_stopped = 1;
      mstate = I_enable ? 1 : 0;
    end else begin
      if (r1 && r2) m_phase = '0;
      else if (r2 && m_arm) m_phase = 32'(edge_n - t_r1);
      if (r1) begin m_dir = mf2; m_arm = 1; end
      else if (r2) m_arm = 0;
      if (mstate == 1) begin
        if (r1) mstate = 2;
      end else begin
        if (r1) begin
          m_period = 32'(edge_n - t_r1);
          m_valid = 1;
          m_stopped = 0;
        end else if (edge_n - t_r1 == longint'(TIMEOUT)) begin
          m_period = '0;
          m_stopped = 1;
          mstate = 1;
        end
      end
      if (r1) t_r1 = edge_n;
    end
    hist1 = {hist1[14:0], I_spd1};
    hist2 = {hist2[14:0], I_spd2};
    f1 = must_flip(hist1, mf1) ? ~mf1 : mf1;
    f2 = must_flip(hist2, mf2) ? ~mf2 : mf2;
    pend1 = f1 && !mf1;
    pend2 = f2 && !mf2;
    mf1 = f1;
    mf2 = f2;
  endtask

  // Single compare process: model vs DUT on every cycle out of reset.
  always @(posedge I_clk) begin
    model_step();
    #1;
    cyc++;
    if (I_reset_n) begin
      check("period", O_period, m_period);
      check("phase", O_phase, m_phase);
      check("dir", {31'd0, O_dir}, {31'd0, m_dir});
      check("pulse_cnt", O_pulse_cnt, m_cnt);
      check("valid", {31'd0, O_valid}, {31'd0, m_valid});
      check("stopped", {31'd0, O_stopped}, {31'd0, m_stopped});
      if (O_valid === 1'b1) begin
        valid_seen++;
        last_valid_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge I_clk);
      I_spd1 = 1'b0; I_spd2 = 1'b0; I_clear = 1'b0;
    end
  endtask

  // Square waves of period per; the lagging channel is delayed by dly cycles.
  task automatic wave(input int per, input int dly, input bit lead, input int nper, input bit noisy);
    for (int c = 0; c < per * nper; c++) begin
      bit a, b;
      a = (c % per) < (per / 2);
      b = ((c + per - dly) % per) < (per / 2);
      @(negedge I_clk);
      I_spd1 = lead ? b : a;
      I_spd2 = lead ? a : b;
      I_clear = 1'b0;
      if (noisy) begin
        if ($urandom_range(0, 15) == 0) I_spd1 = ~I_spd1;
        if ($urandom_range(0, 15) == 0) I_spd2 = ~I_spd2;
        I_clear = ($urandom_range(0, 63) == 0);
      end
    end
    @(negedge I_clk);
    I_spd1 = 1'b0; I_spd2 = 1'b0; I_clear = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_period"}, O_period, 32'd0);
    check({tag, "_phase"}, O_phase, 32'd0);
    check({tag, "_dir"}, {31'd0, O_dir}, 32'd0);
    check({tag, "_cnt"}, O_pulse_cnt, 32'd0);
    check({tag, "_valid"}, {31'd0, O_valid}, 32'd0);
    check({tag, "_stopped"}, {31'd0, O_stopped}, 32'd1);
  endtask

  initial begin
    #(40 * 80000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int vs0, per, dly, nper, sel;
    bit lead, stop_seen;

    repeat (3) @(negedge I_clk);
    check_reset_values("reset");
    I_reset_n = 1'b1;
    I_enable = 1'b1;
    idle(5);

    // 1: ch2 lags by 25, period 100
    $display("step 1: period 100, ch2 lag 25, 5 periods");
    vs0 = valid_seen;
    wave(100, 25, 1'b0, 5, 1'b0);
    idle(10);
    check("t1_period", O_period, 32'd100);
    check("t1_phase", O_phase, 32'd25);
    check("t1_dir", {31'd0, O_dir}, 32'd0);
    check("t1_cnt", O_pulse_cnt, 32'd5);
    check("t1_stopped", {31'd0, O_stopped}, 32'd0);
    check("t1_valid_count", valid_seen - vs0, 32'd4);

    // 2: count to 2, then ch2 leads by 25 for 4 rises
    $display("step 2: clear, 2 lag rises, 4 lead rises");
    @(negedge I_clk); I_clear = 1'b1;
    @(negedge I_clk); I_clear = 1'b0;
    wave(100, 25, 1'b0, 2, 1'b0);
    idle(10);
    check("t2_cnt_start", O_pulse_cnt, 32'd2);
    wave(100, 25, 1'b1, 4, 1'b0);
    idle(10);
    check("t2_dir", {31'd0, O_dir}, 32'd1);
    check("t2_cnt", O_pulse_cnt, 32'hFFFF_FFFE);

    // 3: glitch filtering
    $display("step 3: 3-cycle glitch then 4-cycle pulse on ch1");
    idle(20);
    vs0 = valid_seen;
    repeat (3) begin @(negedge I_clk); I_spd1 = 1'b1; end
    idle(20);
    check("t3_glitch_cnt", O_pulse_cnt, 32'hFFFF_FFFE);
    check("t3_glitch_valid", valid_seen - vs0, 32'd0);
    repeat (4) begin @(negedge I_clk); I_spd1 = 1'b1; end
    idle(20);
    check("t3_pulse_cnt", O_pulse_cnt, 32'hFFFF_FFFF);
    check("t3_pulse_dir", {31'd0, O_dir}, 32'd0);

    // 4: stop detection and restart
    $display("step 4: run then stop ch1, expect timeout");
    wave(100, 25, 1'b0, 3, 1'b0);
    stop_seen = 1'b0;
    for (int i = 0; i < 2000 && !stop_seen; i++) begin
      @(negedge I_clk);
      if (O_stopped === 1'b1) stop_seen = 1'b1;
    end
    check("t4_stop_seen", {31'd0, stop_seen}, 32'd1);
    check("t4_stop_delay", cyc - last_valid_cyc, 32'd1000);
    check("t4_period_zero", O_period, 32'd0);
    vs0 = valid_seen;
    wave(100, 25, 1'b0, 2, 1'b0);
    idle(10);
    check("t4_restart_valids", valid_seen - vs0, 32'd1);
    check("t4_restart_period", O_period, 32'd100);
    check("t4_restart_stopped", {31'd0, O_stopped}, 32'd0);

    // 5: clear coincident with r1 (rise sampled at edge t, r1 acts at edge t+6)
    $display("step 5: clear coincident with ch1 rise");
    @(negedge I_clk); I_spd1 = 1'b1;
    repeat (6) @(negedge I_clk);
    I_clear = 1'b1;
    @(negedge I_clk); I_clear = 1'b0;
    check("t5_clear_cnt", O_pulse_cnt, 32'd0);
    repeat (50) @(negedge I_clk);
    idle(50);
    @(negedge I_clk); I_spd1 = 1'b1;
    repeat (12) @(negedge I_clk);
    check("t5_next_cnt", O_pulse_cnt, 32'd1);
    idle(60);

    // 6: asynchronous reset mid-run, then disable
    $display("step 6: reset mid-run, then disable");
    wave(100, 25, 1'b0, 3, 1'b0);
    @(negedge I_clk);
    I_reset_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    repeat (3) @(negedge I_clk);
    I_reset_n = 1'b1;
    idle(5);
    wave(100, 25, 1'b0, 3, 1'b0);
    idle(10);
    check("t6_cnt", O_pulse_cnt, 32'd3);
    @(negedge I_clk); I_enable = 1'b0;
    repeat (3) @(negedge I_clk);
    check("t6_idle_stopped", {31'd0, O_stopped}, 32'd1);
    check("t6_idle_period", O_period, 32'd100);
    check("t6_idle_cnt", O_pulse_cnt, 32'd3);
    I_clear = 1'b1;
    @(negedge I_clk); I_clear = 1'b0;
    check("t6_idle_clear", O_pulse_cnt, 32'd0);
    I_enable = 1'b1;
    idle(5);

    // Randomized segments, model-checked every cycle
    for (int s = 0; s < 40; s++) begin
      per  = $urandom_range(16, 120);
      dly  = $urandom_range(1, per / 2 - 1);
      lead = 1'($urandom_range(0, 1));
      nper = $urandom_range(2, 5);
      $display("segment %0d: period %0d delay %0d lead %0d periods %0d", s, per, dly, lead, nper);
      wave(per, dly, lead, nper, 1'b1);
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        @(negedge I_clk); I_enable = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge I_clk);
        I_enable = 1'b1;
      end else if (sel == 1) begin
        @(negedge I_clk); I_reset_n = 1'b0;
        repeat (2) @(negedge I_clk);
        I_reset_n = 1'b1;
      end else if (sel == 2) begin
        idle(TIMEOUT + 100);
      end else begin
        idle($urandom_range(0, 30));
      end
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
